// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the PC, issues single-outstanding memory
// requests and holds one fetched instruction for the decoder handshake.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [5:0]  opcode,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        drop;
    logic        capture;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] next_word(input logic [31:0] a);
        return a + 32'd4;
    endfunction

    // A response is kept only when no redirect has overtaken it.
    assign capture = (state == S_WAIT) && imem_rvalid && !drop && !redirect;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (imem_gnt) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) state_nxt = (drop || redirect) ? S_REQ : S_HOLD;
            end
            S_HOLD: begin
                if (inst_ready || redirect) state_nxt = S_REQ;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state == S_REQ);
        imem_addr = pc;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc     <= word_align(RESET_PC);
            req_pc <= '0;
            drop   <= 1'b0;
        end else begin
            if (redirect) begin
                pc <= word_align(redirect_pc);
            end else if (capture) begin
                pc <= next_word(req_pc);
            end

            if (state == S_REQ && imem_gnt) begin
                req_pc <= pc;
                drop   <= redirect;
            end else if (state == S_WAIT) begin
                if (imem_rvalid) begin
                    drop <= 1'b0;
                end else if (redirect) begin
                    drop <= 1'b1;
                end
            end
        end
    end

    // Output buffer toward the decoder
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            opcode     <= '0;
        end else begin
            if (capture) begin
                inst_valid <= 1'b1;
                inst       <= imem_rdata;
                inst_pc    <= req_pc;
                opcode     <= imem_rdata[31:26];
            end else if (state == S_HOLD && (inst_ready || redirect)) begin
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a small memory responder plus a scoreboard of
// fetched words that are compared when the decoder handshake completes.
module tb_inst_fetch;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_ent_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst, inst_pc;
    logic [5:0]  opcode;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        imem_req2, imem_gnt2 = 1'b0, imem_rvalid2 = 1'b0;
    logic [31:0] imem_addr2, imem_rdata2 = '0;
    logic        inst_valid2;
    logic [31:0] inst2, inst_pc2;
    logic [5:0]  opcode2;

    inst_fetch dut (
        .clk(clk), .resetn(resetn),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .opcode(opcode),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .resetn(resetn),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .inst_valid(inst_valid2), .inst_ready(1'b1),
        .inst(inst2), .inst_pc(inst_pc2), .opcode(opcode2),
        .redirect(1'b0), .redirect_pc(32'h0)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int accepted = 0;

    // memory responder / scoreboard state
    bit          pend = 0, pend2 = 0, model_drop = 0;
    int          pend_cnt = 0, stall_cnt = 0, gnt_stall = 0, rv_delay = 0;
    logic [31:0] pend_addr = '0, pend_addr2 = '0;
    bit          ovr_en = 0;
    logic [31:0] ovr_addr = '0, ovr_data = '0;
    bit          last_gnt = 0;
    logic [31:0] last_gaddr = '0;
    sb_ent_t     sb[$];
    logic [31:0] gaddr[$];
    int          gcyc[$];
    logic [31:0] gaddr2[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (ovr_en && a == ovr_addr) ? ovr_data : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt);
        bit          was_pend, rv_now, gnt_now;
        logic [31:0] rv_addr;
        sb_ent_t     e;
        @(negedge clk);
        cyc++;
        last_gnt = 0;
        was_pend = pend;
        rv_now   = 0;
        rv_addr  = pend_addr;
        if (pend) begin
            if (pend_cnt == 0) begin
                rv_now = 1;
                pend   = 0;
            end else begin
                pend_cnt--;
            end
        end
        gnt_now = 0;
        if (imem_req) begin
            if (stall_cnt > 0) stall_cnt--;
            else gnt_now = 1;
        end
        if (gnt_now) begin
            pend = 1; pend_cnt = rv_delay; pend_addr = imem_addr;
            stall_cnt = gnt_stall;
            gaddr.push_back(imem_addr); gcyc.push_back(cyc);
            last_gnt = 1; last_gaddr = imem_addr;
            if (redir) model_drop = 1;
        end
        if (rv_now) begin
            if (model_drop || redir) model_drop = 0;
            else sb.push_back({rv_addr, mem_word(rv_addr)});
        end else if (was_pend && redir) begin
            model_drop = 1;
        end
        if (inst_valid && (rdy || redir)) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (rdy) begin
                    accepted++;
                    chk("inst", inst, e.data);
                    chk("inst_pc", inst_pc, e.addr);
                    chk("opcode", 32'(opcode), 32'(e.data[31:26]));
                end
            end
        end
        imem_gnt    = gnt_now;
        imem_rvalid = rv_now;
        imem_rdata  = rv_now ? mem_word(rv_addr) : $urandom;
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = tgt;
        // second instance: always-grant memory with one-cycle read latency
        imem_rvalid2 = pend2;
        imem_rdata2  = pend_addr2 ^ 32'hA5A5_0000;
        pend2 = 0;
        imem_gnt2 = imem_req2;
        if (imem_req2) begin
            pend2 = 1; pend_addr2 = imem_addr2;
            gaddr2.push_back(imem_addr2);
        end
    endtask

    task automatic wait_grant(input string tag, input bit rdy, input logic [31:0] a);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(rdy, 1'b0, 32'h0);
            if (last_gnt && last_gaddr == a) found = 1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic clear_model();
        pend = 0; pend2 = 0; model_drop = 0; stall_cnt = gnt_stall;
        sb.delete(); gaddr.delete(); gcyc.delete(); gaddr2.delete();
        accepted = 0;
        imem_gnt = 0; imem_rvalid = 0; inst_ready = 0; redirect = 0;
        imem_gnt2 = 0; imem_rvalid2 = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #50_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        // reset state
        clear_model();
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // T1: streaming fetch, one instruction per three cycles
        wait_grant("t1_grant12", 1'b1, 32'd12);
        chk("t1_ngrants", 32'(gaddr.size()), 32'd4);
        for (int i = 0; i < 4 && i < gaddr.size(); i++) chk("t1_addr", gaddr[i], 32'(4 * i));
        for (int i = 1; i < 4 && i < gcyc.size(); i++) chk("t1_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        chk("t1_accepted", 32'(accepted), 32'd4);
        // T5: RESET_PC at top of address space wraps to zero
        chk("t5_ngrants", 32'(gaddr2.size() >= 2), 32'd1);
        if (gaddr2.size() >= 2) begin
            chk("t5_first", gaddr2[0], 32'hFFFF_FFFC);
            chk("t5_second", gaddr2[1], 32'h0000_0000);
        end

        // T2: decoder back-pressure holds the buffered instruction
        do_reset();
        ovr_en = 1; ovr_addr = 32'h0; ovr_data = 32'h8C08_0004;
        wait_grant("t2_grant0", 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("t2_valid", 32'(inst_valid), 32'd1);
            chk("t2_inst", inst, 32'h8C08_0004);
            chk("t2_inst_pc", inst_pc, 32'h0);
            chk("t2_opcode", 32'(opcode), 32'h23);
            chk("t2_req", 32'(imem_req), 32'd0);
        end
        step(1'b1, 1'b0, 32'h0);
        chk("t2_accepted", 32'(accepted), 32'd1);
        step(1'b1, 1'b0, 32'h0);
        chk("t2_next_gnt", 32'(last_gnt), 32'd1);
        chk("t2_next_addr", last_gaddr, 32'h4);
        ovr_en = 0;

        // T3: redirect while waiting for the response of address 8
        do_reset();
        rv_delay = 1;
        wait_grant("t3_grant8", 1'b1, 32'h8);
        a0 = accepted;
        step(1'b1, 1'b1, 32'h0000_0043);
        chk("t3_valid_a", 32'(inst_valid), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        chk("t3_valid_b", 32'(inst_valid), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        chk("t3_redirect_gnt", 32'(last_gnt), 32'd1);
        chk("t3_redirect_addr", last_gaddr, 32'h0000_0040);
        chk("t3_no_accept", 32'(accepted), 32'(a0));
        rv_delay = 0;

        // T4: redirect in S_HOLD with and without decoder ready
        do_reset();
        wait_grant("t4_grant10", 1'b1, 32'h10);
        step(1'b1, 1'b0, 32'h0);
        a0 = accepted;
        step(1'b1, 1'b1, 32'h0000_0100);
        chk("t4_consumed", 32'(accepted), 32'(a0 + 1));
        step(1'b1, 1'b0, 32'h0);
        chk("t4_tgt_addr", last_gaddr, 32'h0000_0100);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0200);
        chk("t4_held_valid", 32'(inst_valid), 32'd1);
        step(1'b1, 1'b0, 32'h0);
        chk("t4_flushed", 32'(inst_valid), 32'd0);
        chk("t4_flush_gnt", last_gaddr, 32'h0000_0200);
        chk("t4_never_acc", 32'(accepted), 32'(a0 + 1));

        // T6: asynchronous reset while a stalled fetch is in flight
        gnt_stall = 3;
        do_reset();
        wait_grant("t6_grant8", 1'b1, 32'h8);
        step(1'b1, 1'b0, 32'h0);
        #3 resetn = 1'b0;
        #1;
        chk("t6_req", 32'(imem_req), 32'd0);
        chk("t6_valid", 32'(inst_valid), 32'd0);
        chk("t6_inst", inst, 32'd0);
        chk("t6_inst_pc", inst_pc, 32'd0);
        chk("t6_opcode", 32'(opcode), 32'd0);
        chk("t6_addr", imem_addr, 32'd0);
        gnt_stall = 0;
        clear_model();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("t6_idle_req", 32'(imem_req), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        chk("t6_restart_gnt", 32'(last_gnt), 32'd1);
        chk("t6_restart_addr", last_gaddr, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("t6_restart_acc", 32'(accepted), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
